// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared types for the pipeline control logic. Holds the
//            hazard-controller state encoding, the bundle of pipeline-register
//            control strobes, and the canonical control patterns.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } pipe_state_e;

  // Control strobes for the PC and the four inter-stage registers.
  typedef struct packed {
    logic pc_write_en;
    logic pc_sel_branch;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_write_en;
    logic id_ex_bubble;
    logic ex_mem_write_en;
    logic mem_wb_write_en;
  } hazard_ctrl_t;

  // Everything frozen: reset and memory stall.
  localparam hazard_ctrl_t c_CTRL_HOLD     = 8'b0000_0000;
  // Normal advance of every register.
  localparam hazard_ctrl_t c_CTRL_RUN      = 8'b1010_1011;
  // Redirect PC and squash the two younger slots in one cycle.
  localparam hazard_ctrl_t c_CTRL_BRANCH   = 8'b1111_1111;
  // Hold PC and IF/ID, insert one bubble into ID/EX, let the back end drain.
  localparam hazard_ctrl_t c_CTRL_LOAD_USE = 8'b0000_1111;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk     - clock
//            i_clear - synchronous clear (wins over i_inc)
//            i_inc   - count one event this cycle
//            o_q     - current count
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Central stall/flush controller for the 5-stage pipeline. Control
//            strobes are a combinational function of state and inputs; memory
//            wait tracking, the sticky timeout flag and the stall/flush
//            performance counters are registered.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            i_id_rs1/2, i_id_uses_rs1/2 - source operands of the ID instr
//            i_ex_rd, i_ex_mem_read, i_ex_rf_write_en - EX instr destination
//            i_ex_branch_taken     - EX resolved a taken branch/jump
//            i_mem_busy            - data memory not ready
//            o_*_write_en/flush/bubble, o_pc_sel_branch - register controls
//            o_mem_timeout         - sticky long-busy flag
//            o_stall_cycles, o_flush_count - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_LEN = 3,
  parameter int CNT_W        = 16,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_LEN-1:0] i_id_rs1,
  input  logic [REG_ADDR_LEN-1:0] i_id_rs2,
  input  logic                    i_id_uses_rs1,
  input  logic                    i_id_uses_rs2,
  input  logic [REG_ADDR_LEN-1:0] i_ex_rd,
  input  logic                    i_ex_mem_read,
  input  logic                    i_ex_rf_write_en,
  input  logic                    i_ex_branch_taken,
  input  logic                    i_mem_busy,
  output logic                    o_pc_write_en,
  output logic                    o_pc_sel_branch,
  output logic                    o_if_id_write_en,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_write_en,
  output logic                    o_id_ex_bubble,
  output logic                    o_ex_mem_write_en,
  output logic                    o_mem_wb_write_en,
  output logic                    o_mem_timeout,
  output logic [CNT_W-1:0]        o_stall_cycles,
  output logic [CNT_W-1:0]        o_flush_count
);

  localparam int                  c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

  pipe_state_e         r_state;
  pipe_state_e         w_state_next;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic [c_WAIT_W-1:0] w_wait_next;
  logic                r_mem_timeout;
  logic                w_timeout_next;
  hazard_ctrl_t        w_ctrl;
  logic                w_load_use;
  logic                w_stall_inc;
  logic                w_flush_inc;

  // R0 is hardwired zero, so a load targeting it can never feed ID.
  assign w_load_use = i_ex_mem_read & i_ex_rf_write_en & (i_ex_rd != '0) &
                      ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    w_ctrl         = c_CTRL_RUN;
    w_state_next   = S_RUN;
    w_wait_next    = '0;
    w_timeout_next = r_mem_timeout;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    if (rst) begin
      w_ctrl         = c_CTRL_HOLD;
      w_timeout_next = 1'b0;
    end else if (i_mem_busy) begin
      w_ctrl       = c_CTRL_HOLD;
      w_state_next = S_MEM_WAIT;
      w_stall_inc  = 1'b1;
      // w_wait_next is the length of the busy run including this cycle.
      if (r_state == S_RUN) begin
        w_wait_next = c_WAIT_W'(1);
      end else if (r_wait_cnt != c_WAIT_MAX) begin
        w_wait_next = r_wait_cnt + 1'b1;
      end else begin
        w_wait_next = r_wait_cnt;
      end
      if (w_wait_next == c_WAIT_MAX) begin
        w_timeout_next = 1'b1;
      end
    end else if (i_ex_branch_taken) begin
      // A branch held in EX across a memory stall lands here on the first
      // non-busy cycle, whichever state we are leaving.
      w_ctrl      = c_CTRL_BRANCH;
      w_flush_inc = 1'b1;
    end else if (w_load_use) begin
      w_ctrl      = c_CTRL_LOAD_USE;
      w_stall_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wait_cnt    <= w_wait_next;
      r_mem_timeout <= w_timeout_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_clear (rst),
    .i_inc   (w_stall_inc),
    .o_q     (o_stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_clear (rst),
    .i_inc   (w_flush_inc),
    .o_q     (o_flush_count)
  );

  assign o_pc_write_en     = w_ctrl.pc_write_en;
  assign o_pc_sel_branch   = w_ctrl.pc_sel_branch;
  assign o_if_id_write_en  = w_ctrl.if_id_write_en;
  assign o_if_id_flush     = w_ctrl.if_id_flush;
  assign o_id_ex_write_en  = w_ctrl.id_ex_write_en;
  assign o_id_ex_bubble    = w_ctrl.id_ex_bubble;
  assign o_ex_mem_write_en = w_ctrl.ex_mem_write_en;
  assign o_mem_wb_write_en = w_ctrl.mem_wb_write_en;
  assign o_mem_timeout     = r_mem_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed-vector bench for pipeline_hazard_ctrl. Each vector
//            carries hand-computed expected controls and the counter/flag
//            values visible during that cycle; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  // Control byte order: pc_we, pc_sel, ifid_we, ifid_flush,
  //                     idex_we, idex_bubble, exmem_we, memwb_we
  localparam logic [7:0] c_HOLD = 8'h00;
  localparam logic [7:0] c_RUN  = 8'hAB;
  localparam logic [7:0] c_BR   = 8'hFF;
  localparam logic [7:0] c_LU   = 8'h0F;

  typedef struct {
    int         id;
    logic [7:0] ctl;
    int         st;
    int         fl;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       uses1 = 1'b0, uses2 = 1'b0, mem_read = 1'b0, rf_we = 1'b0;
  logic       br = 1'b0, busy = 1'b0;
  logic       pc_we, pc_sel, ifid_we, ifid_fl, idex_we, idex_bub, exmem_we, memwb_we;
  logic       mem_to;
  logic [3:0] stall_cnt, flush_cnt;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_LEN (3),
    .CNT_W        (4),
    .MEM_TIMEOUT  (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_id_rs1          (id_rs1),
    .i_id_rs2          (id_rs2),
    .i_id_uses_rs1     (uses1),
    .i_id_uses_rs2     (uses2),
    .i_ex_rd           (ex_rd),
    .i_ex_mem_read     (mem_read),
    .i_ex_rf_write_en  (rf_we),
    .i_ex_branch_taken (br),
    .i_mem_busy        (busy),
    .o_pc_write_en     (pc_we),
    .o_pc_sel_branch   (pc_sel),
    .o_if_id_write_en  (ifid_we),
    .o_if_id_flush     (ifid_fl),
    .o_id_ex_write_en  (idex_we),
    .o_id_ex_bubble    (idex_bub),
    .o_ex_mem_write_en (exmem_we),
    .o_mem_wb_write_en (memwb_we),
    .o_mem_timeout     (mem_to),
    .o_stall_cycles    (stall_cnt),
    .o_flush_count     (flush_cnt)
  );

  // Drive one cycle of inputs just after the edge and queue its expectation.
  task automatic vec(input int id, input logic r,
                     input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic u1, input logic u2, input logic [2:0] rd,
                     input logic mr, input logic rfw, input logic b,
                     input logic bz, input logic [7:0] ctl,
                     input int st, input int fl, input logic to);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; uses1 = u1; uses2 = u2;
    ex_rd = rd; mem_read = mr; rf_we = rfw; br = b; busy = bz;
    e.id = id; e.ctl = ctl; e.st = st; e.fl = fl; e.to = to;
    sb.push_back(e);
  endtask

  task automatic idle(input int id, input int st, input int fl, input logic to);
    vec(id, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_RUN, st, fl, to);
  endtask

  task automatic busy_cyc(input int id, input logic b, input int st, input int fl, input logic to);
    vec(id, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, b, 1'b1, c_HOLD, st, fl, to);
  endtask

  // Monitor: the controller presents a full output set every cycle.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {pc_we, pc_sel, ifid_we, ifid_fl, idex_we, idex_bub, exmem_we, memwb_we};
        n_tests++;
        if (act !== e.ctl) begin
          n_fail++;
          $display("FAIL vec%0d ctl: got %b expected %b", e.id, act, e.ctl);
        end
        n_tests++;
        if (int'(stall_cnt) != e.st || $isunknown(stall_cnt)) begin
          n_fail++;
          $display("FAIL vec%0d stall_cycles: got %0d expected %0d", e.id, stall_cnt, e.st);
        end
        n_tests++;
        if (int'(flush_cnt) != e.fl || $isunknown(flush_cnt)) begin
          n_fail++;
          $display("FAIL vec%0d flush_count: got %0d expected %0d", e.id, flush_cnt, e.fl);
        end
        n_tests++;
        if (mem_to !== e.to) begin
          n_fail++;
          $display("FAIL vec%0d mem_timeout: got %b expected %b", e.id, mem_to, e.to);
        end
      end
    end
  end

  initial begin
    // Reset held two cycles.
    vec(1, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_HOLD, 0, 0, 1'b0);
    vec(2, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_HOLD, 0, 0, 1'b0);
    idle(3, 0, 0, 1'b0);
    // Load-use on rs2.
    vec(4, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, c_LU, 0, 0, 1'b0);
    idle(5, 1, 0, 1'b0);
    // Load to R0 never hazards.
    vec(6, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, c_RUN, 1, 0, 1'b0);
    // Load-use on rs1.
    vec(7, 1'b0, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, c_LU, 1, 0, 1'b0);
    // Matching register but operand not used / not a writing load.
    vec(8, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, c_RUN, 2, 0, 1'b0);
    vec(9, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, c_RUN, 2, 0, 1'b0);
    vec(10, 1'b0, 3'd0, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, c_RUN, 2, 0, 1'b0);
    // Branch beats load-use.
    vec(11, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, c_BR, 2, 0, 1'b0);
    idle(12, 2, 1, 1'b0);
    // Four busy cycles with a branch held in EX, flush on the fifth.
    for (int k = 0; k < 4; k++) busy_cyc(13 + k, 1'b1, 2 + k, 1, 1'b0);
    vec(17, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_BR, 6, 1, 1'b0);
    idle(18, 6, 2, 1'b0);
    // Ten busy cycles: timeout visible from the 9th, stall count saturates.
    for (int k = 0; k < 10; k++)
      busy_cyc(20 + k, 1'b0, (6 + k > 15) ? 15 : 6 + k, 2, (k >= 8) ? 1'b1 : 1'b0);
    idle(30, 15, 2, 1'b1);
    vec(31, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, c_BR, 15, 2, 1'b1);
    // Twenty more busy cycles: counter pinned at 15, flag stays set.
    for (int k = 0; k < 20; k++) busy_cyc(40 + k, 1'b0, 15, 3, 1'b1);
    vec(60, 1'b0, 3'd0, 3'd3, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, c_LU, 15, 3, 1'b1);
    idle(61, 15, 3, 1'b1);
    // Reset clears everything.
    vec(62, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_HOLD, 15, 3, 1'b1);
    idle(63, 0, 0, 1'b0);
    // Reset in the middle of a wait: 5 + 4 busy cycles must not time out.
    for (int k = 0; k < 5; k++) busy_cyc(70 + k, 1'b0, k, 0, 1'b0);
    vec(75, 1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, c_HOLD, 5, 0, 1'b0);
    for (int k = 0; k < 4; k++) busy_cyc(76 + k, 1'b0, k, 0, 1'b0);
    idle(80, 4, 0, 1'b0);
    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
